rst_seq: RTL and testbench



---
 rtl/rst_seq.sv | 168 ++++++++++++++++
 tb/tb_rst_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
// Reset sequencer: filters and synchronises PLL lock, holds downstream logic
// in reset until the clock is stable, then releases STAGES active-low reset
// domains in a staggered order. Loss of lock or a software reset request
// drops every domain back into reset.
module rst_seq #(
  parameter int STAGES    = 3,
  parameter int LOCK_FILT = 16,
  parameter int HOLD      = 64,
  parameter int GAP       = 8,
  parameter int SYNC      = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              lock_i,
  input  logic              sw_rst_i,
  output logic [STAGES-1:0] rst_n_o,
  output logic              ready_o,
  output logic [1:0]        state_o,
  output logic [7:0]        loss_cnt_o
);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_HOLD      = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  // Each counter is sized to hold its terminal value without wrapping.
  localparam int FW = $clog2(LOCK_FILT) + 1;
  localparam int HW = $clog2(HOLD) + 1;
  localparam int GW = $clog2(GAP) + 1;

  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

  logic [SYNC-1:0]   sync_q;
  logic              lock_s;
  logic              lock_lost;

  state_t            state_q,  state_d;
  logic [FW-1:0]     filt_q,   filt_d;
  logic [HW-1:0]     hold_q,   hold_d;
  logic [GW-1:0]     gap_q,    gap_d;
  logic [STAGES-1:0] rst_q,    rst_d;
  logic              ready_q,  ready_d;
  logic [7:0]        loss_q,   loss_d;

  // Bring the asynchronous lock indication into the clk_i domain.
  // NOTE: the synchroniser flops are reset as well, so lock_s reads a known 0
  // until lock_i has actually propagated through SYNC edges.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], lock_i};
    end
  end

  assign lock_s    = sync_q[SYNC-1];
  // Losing lock only counts once the sequencer has left WAIT_LOCK.
  assign lock_lost = !lock_s && (state_q != S_WAIT_LOCK);

  // State, counters and every output are registered here.
  // NOTE: sequential state uses <= so all flops update from pre-edge values,
  // independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_WAIT_LOCK;
      filt_q  <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
      rst_q   <= '0;
      ready_q <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      loss_q  <= loss_d;
    end
  end

  // Next-state and next-output decode; lock loss outranks software reset.
  // NOTE: every signal gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    loss_d  = loss_q;

    if (lock_lost) begin
      state_d = S_WAIT_LOCK;
      filt_d  = '0;
      hold_d  = '0;
      gap_d   = '0;
      rst_d   = '0;
      ready_d = 1'b0;
      if (loss_q != 8'hFF) begin
        loss_d = loss_q + 8'd1;
      end
    end else if (sw_rst_i && (state_q != S_WAIT_LOCK)) begin
      // Parks in HOLD at count 0 for as long as the request stays high.
      state_d = S_HOLD;
      filt_d  = '0;
      hold_d  = '0;
      gap_d   = '0;
      rst_d   = '0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          if (!lock_s) begin
            filt_d = '0;
          end else if (filt_q == FILT_LAST) begin
            state_d = S_HOLD;
            filt_d  = '0;
          end else begin
            filt_d = filt_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            // Stage 0 is released on the very edge that enters RELEASE.
            state_d = S_RELEASE;
            hold_d  = '0;
            gap_d   = '0;
            rst_d   = STAGES'(1);
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (&rst_q) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end else if (gap_q == GAP_LAST) begin
            // Shifting a 1 in from the bottom keeps the release order monotonic.
            gap_d = '0;
            rst_d = (rst_q << 1) | STAGES'(1);
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        S_RUN: begin
          ready_d = 1'b1;
        end
        default: begin
          state_d = S_WAIT_LOCK;
        end
      endcase
    end
  end

  assign rst_n_o    = rst_q;
  assign ready_o    = ready_q;
  assign state_o    = state_q;
  assign loss_cnt_o = loss_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: a default build and a STAGES=1/GAP=1 build share the
// same lock/sw stimulus. A timeline model (edges since sequence start) is
// compared against both on every cycle; directed milestones pin the model.
module tb_rst_seq;

  localparam int S0 = 3, F0 = 16, H0 = 64, G0 = 8;
  localparam int S1 = 1, F1 = 2,  H1 = 4,  G1 = 1;
  localparam int SY = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lock;
  logic        sw;

  logic [2:0]  rst0;
  logic        ready0;
  logic [1:0]  state0;
  logic [7:0]  loss0;
  logic [0:0]  rst1;
  logic        ready1;
  logic [1:0]  state1;
  logic [7:0]  loss1;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  rst_seq #(.STAGES(S0), .LOCK_FILT(F0), .HOLD(H0), .GAP(G0), .SYNC(SY)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .lock_i(lock), .sw_rst_i(sw),
    .rst_n_o(rst0), .ready_o(ready0), .state_o(state0), .loss_cnt_o(loss0)
  );

  rst_seq #(.STAGES(S1), .LOCK_FILT(F1), .HOLD(H1), .GAP(G1), .SYNC(SY)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .lock_i(lock), .sw_rst_i(sw),
    .rst_n_o(rst1), .ready_o(ready1), .state_o(state1), .loss_cnt_o(loss1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // seq=0: waiting for lock (run = consecutive lock_s highs seen).
  // seq=1: t = edges since the sequence (re)started in HOLD; all outputs are
  // plain functions of t.
  typedef struct {
    bit seq;
    int run;
    int t;
    int loss;
  } mdl_t;

  mdl_t m0, m1;
  bit   q0[$], q1[$];

  task automatic mdl_step(inout mdl_t m, input bit ls, input bit s, input int filt);
    if (m.seq && !ls) begin
      m.seq = 1'b0; m.run = 0; m.t = 0;
      if (m.loss < 255) m.loss++;
    end else if (m.seq && s) begin
      m.t = 0;
    end else if (m.seq) begin
      if (m.t < (1 << 20)) m.t++;
    end else if (ls) begin
      m.run++;
      if (m.run == filt) begin
        m.seq = 1'b1; m.t = 0; m.run = 0;
      end
    end else begin
      m.run = 0;
    end
  endtask

  function automatic int exp_rst(mdl_t m, int stages, int hold, int gap);
    int r = 0;
    for (int k = 0; k < stages; k++)
      if (m.seq && m.t >= hold + gap * k) r |= (1 << k);
    return r;
  endfunction

  function automatic int exp_ready(mdl_t m, int stages, int hold, int gap);
    return (m.seq && m.t >= hold + gap * (stages - 1) + 1) ? 1 : 0;
  endfunction

  function automatic int exp_state(mdl_t m, int stages, int hold, int gap);
    if (!m.seq) return 0;
    if (m.t < hold) return 1;
    return exp_ready(m, stages, hold, gap) != 0 ? 3 : 2;
  endfunction

  // Model advance; the queue delays lock by SYNC edges.
  always @(posedge clk or negedge rst_n) begin : model
    bit ls;
    if (!rst_n) begin
      m0 = '{0, 0, 0, 0};
      m1 = '{0, 0, 0, 0};
      q0 = {};
      q1 = {};
      for (int i = 0; i < SY; i++) begin
        q0.push_back(1'b0);
        q1.push_back(1'b0);
      end
    end else begin
      ls = q0.pop_front(); q0.push_back(lock); mdl_step(m0, ls, sw, F0);
      ls = q1.pop_front(); q1.push_back(lock); mdl_step(m1, ls, sw, F1);
    end
  end

  // Per-cycle comparison of both builds against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_rst0",   rst0,   exp_rst(m0, S0, H0, G0));
      check("cmp_ready0", ready0, exp_ready(m0, S0, H0, G0));
      check("cmp_state0", state0, exp_state(m0, S0, H0, G0));
      check("cmp_loss0",  loss0,  m0.loss);
      check("cmp_rst1",   rst1,   exp_rst(m1, S1, H1, G1));
      check("cmp_ready1", ready1, exp_ready(m1, S1, H1, G1));
      check("cmp_state1", state1, exp_state(m1, S1, H1, G1));
      check("cmp_loss1",  loss1,  m1.loss);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_state(input string name, input logic [1:0] want, input int limit);
    bit hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      if (state0 == want) hit = 1'b1;
    end
    check(name, hit, 1);
  endtask

  // Called at a negedge with the sequencer in WAIT_LOCK and lock_s low.
  // Edge n is the n-th posedge after lock goes high.
  task automatic milestones(input string tag);
    lock = 1'b1;
    for (int n = 1; n <= 99; n++) begin
      @(posedge clk);
      #1;
      case (n)
        3:  check({tag, "_s1_state_e3"}, state1, 0);
        4:  check({tag, "_s1_state_e4"}, state1, 1);
        7:  check({tag, "_s1_rst_e7"}, rst1, 0);
        8:  begin
              check({tag, "_s1_rst_e8"}, rst1, 1);
              check({tag, "_s1_ready_e8"}, ready1, 0);
            end
        9:  check({tag, "_s1_ready_e9"}, ready1, 1);
        17: check({tag, "_state_e17"}, state0, 0);
        18: check({tag, "_state_e18"}, state0, 1);
        81: check({tag, "_rst_e81"}, rst0, 3'b000);
        82: begin
              check({tag, "_rst_e82"}, rst0, 3'b001);
              check({tag, "_state_e82"}, state0, 2);
            end
        89: check({tag, "_rst_e89"}, rst0, 3'b001);
        90: check({tag, "_rst_e90"}, rst0, 3'b011);
        97: check({tag, "_rst_e97"}, rst0, 3'b011);
        98: begin
              check({tag, "_rst_e98"}, rst0, 3'b111);
              check({tag, "_ready_e98"}, ready0, 0);
            end
        99: begin
              check({tag, "_ready_e99"}, ready0, 1);
              check({tag, "_state_e99"}, state0, 3);
            end
        default: ;
      endcase
      @(negedge clk);
    end
  endtask

  // Drop lock in a released state: lock_s falls after SYNC edges, outputs
  // collapse on the following edge.
  task automatic drop_lock(input string tag, input int want_loss);
    lock = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk);
      #1;
      if (n == 2) check({tag, "_still_ready"}, ready0, 1);
      if (n == 3) begin
        check({tag, "_rst"}, rst0, 3'b000);
        check({tag, "_ready"}, ready0, 0);
        check({tag, "_state"}, state0, 0);
        check({tag, "_loss"}, loss0, want_loss);
      end
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    lock  = 1'b1;
    sw    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rst0",   rst0,   0);
    check("rst_ready0", ready0, 0);
    check("rst_state0", state0, 0);
    check("rst_loss0",  loss0,  0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // Clean power-up sequence.
    milestones("boot");

    // Lock lost in RUN, then regained: identical timing.
    drop_lock("loss1", 1);
    milestones("relock");

    // Lock glitch in WAIT_LOCK: 10 high, 1 low, then high. The filter sees
    // lock_s at edges 3..12, low at 13, then needs 16 more (14..29).
    drop_lock("loss2", 2);
    for (int n = 1; n <= 29; n++) begin
      lock = (n == 11) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (n == 28) check("glitch_state_e28", state0, 0);
      if (n == 29) begin
        check("glitch_state_e29", state0, 1);
        check("glitch_loss", loss0, 2);
      end
      @(negedge clk);
    end

    // One-cycle software reset in RUN: HOLD at edge 1, ready again 81 edges later.
    wait_state("wait_run_sw", 2'd3, 300);
    sw = 1'b1;
    for (int n = 1; n <= 82; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        check("sw_rst", rst0, 3'b000);
        check("sw_state", state0, 1);
        check("sw_loss", loss0, 2);
      end
      if (n == 81) check("sw_ready_e81", ready0, 0);
      if (n == 82) check("sw_ready_e82", ready0, 1);
      @(negedge clk);
      sw = 1'b0;
    end

    // Lock loss and software reset on the same edge: lock loss wins.
    lock = 1'b0;
    repeat (2) @(negedge clk);
    sw = 1'b1;
    @(posedge clk);
    #1;
    check("both_state", state0, 0);
    check("both_loss", loss0, 3);
    @(negedge clk);
    sw = 1'b0;

    // Randomised lock/sw traffic; at least 300 counted lock-loss events.
    for (int it = 0; it < 300; it++) begin
      int hi, lo;
      hi = $urandom_range(90, 16);
      lo = $urandom_range(5, 1);
      lock = 1'b1;
      for (int c = 0; c < hi; c++) begin
        sw = ($urandom_range(31, 0) == 0);
        @(negedge clk);
      end
      sw   = 1'b0;
      lock = 1'b0;
      repeat (lo) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("sat_loss0", loss0, 255);
    check("sat_loss1", loss1, 255);

    // Asynchronous reset while stage 0 alone is released.
    lock = 1'b1;
    wait_state("wait_release", 2'd2, 300);
    check("mid_rel_rst", rst0, 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rst0",   rst0,   0);
    check("arst_ready0", ready0, 0);
    check("arst_state0", state0, 0);
    check("arst_loss0",  loss0,  0);
    check("arst_rst1",   rst1,   0);
    check("arst_loss1",  loss1,  0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
